// File: rtl/tile_stream_reader.sv
// tile_stream_reader
// Read sequencer for a single-port tile memory holding one packed 4x4 int8
// tile per word. A start pulse launches a burst of num_words_i consecutive
// reads from base_addr_i. Each combinational read word is captured into a
// registered output stage and streamed to the compute array over valid/ready
// at one word per cycle.
module tile_stream_reader #(
  parameter int DataWidth = 8*4*4,
  parameter int DataDepth = 1024,
  parameter int AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [AddrWidth-1:0]        base_addr_i,
  input  logic [AddrWidth:0]          num_words_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [AddrWidth-1:0]        mem_addr_o,
  output logic                        mem_we_o,
  input  logic signed [DataWidth-1:0] mem_rd_data_i,
  output logic signed [DataWidth-1:0] data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        last_o
);

  // One int8 element per lane of the packed tile.
  localparam int NumLanes = DataWidth / 8;

  localparam logic [AddrWidth:0]   RemOne  = {{AddrWidth{1'b0}}, 1'b1};
  localparam logic [AddrWidth-1:0] AddrOne = {{(AddrWidth-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  state_e               state_reg, state_next;
  logic [AddrWidth-1:0] addr_reg, addr_next;
  logic [AddrWidth:0]   rem_reg, rem_next;
  logic                 valid_reg, valid_next;
  logic                 last_reg, last_next;
  logic                 done_reg, done_next;

  // High in the cycle the output stage captures the current read word.
  logic                 data_load;

  // Output stage, one register per int8 lane.
  logic signed [7:0]    lane_reg [NumLanes];

  // State and control registers; async reset aborts any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      rem_reg   <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      rem_reg   <= rem_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      done_reg  <= done_next;
    end
  end

  // Next-state and datapath control; every register holds unless a branch
  // below moves it, which gives backpressure for free in FETCH.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rem_next   = rem_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    done_next  = 1'b0;
    data_load  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (num_words_i != '0) begin
            addr_next  = base_addr_i;
            rem_next   = num_words_i;
            state_next = FETCH;
          end else begin
            // Empty transfer: report completion without issuing a beat.
            done_next = 1'b1;
          end
        end
      end

      FETCH: begin
        // The output stage can take a new word when it is empty or its
        // current word is being consumed this cycle.
        if (!valid_reg || ready_i) begin
          data_load  = 1'b1;
          valid_next = 1'b1;
          last_next  = (rem_reg == RemOne);
          addr_next  = addr_reg + AddrOne;  // wraps modulo 2**AddrWidth
          rem_next   = rem_reg - RemOne;
          if (rem_reg == RemOne) begin
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Wait for the final beat to be accepted, then signal completion.
        if (valid_reg && ready_i) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-lane output registers: capture the read word on data_load, else hold.
  for (genvar gi = 0; gi < NumLanes; gi++) begin : g_lane
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lane_reg[gi] <= '0;
      end else if (data_load) begin
        lane_reg[gi] <= mem_rd_data_i[gi*8 +: 8];
      end
    end

    assign data_o[gi*8 +: 8] = lane_reg[gi];
  end

  assign busy_o     = (state_reg != IDLE);
  assign done_o     = done_reg;
  assign mem_addr_o = addr_reg;
  assign mem_we_o   = 1'b0;
  assign valid_o    = valid_reg;
  assign last_o     = last_reg;

endmodule

// File: tb/tb_tile_stream_reader.sv
// tb_tile_stream_reader
// Directed bench for tile_stream_reader. A behavioural memory holds
// mem[i] = i, so every streamed word equals the address it was read from.
module tb_tile_stream_reader;

  localparam int DW     = 128;
  localparam int DD     = 1024;
  localparam int AW     = 10;
  localparam int AW1    = AW + 1;
  localparam int MaxCyc = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   num_words_i = '0;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [DW-1:0] mem_rd_data_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic          last_o;

  logic [DW-1:0] mem [DD];

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-transfer capture
  int            beat_cnt;
  logic [DW-1:0] beat_data [16];
  logic          beat_last [16];
  int            beat_cyc  [16];
  int            done_cyc;
  logic [63:0]   busy_bits;
  logic          cyc_valid [MaxCyc];
  logic [DW-1:0] cyc_data  [MaxCyc];
  logic [AW-1:0] cyc_addr  [MaxCyc];

  int exp_cyc_t2 [4] = '{2, 7, 8, 9};

  always #5 clk_i = ~clk_i;

  assign mem_rd_data_i = mem[mem_addr_o];

  tile_stream_reader dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .num_words_i   (num_words_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_rd_data_i (mem_rd_data_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .last_o        (last_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},  DW'(busy_o),     DW'(0));
    check_eq({tag, "_done"},  DW'(done_o),     DW'(0));
    check_eq({tag, "_addr"},  DW'(mem_addr_o), DW'(0));
    check_eq({tag, "_data"},  data_o,          DW'(0));
    check_eq({tag, "_valid"}, DW'(valid_o),    DW'(0));
    check_eq({tag, "_last"},  DW'(last_o),     DW'(0));
  endtask

  // Start a transfer in cycle 0 and record every cycle until done_o.
  // low_mask bit c drops ready_i in cycle c; ss_cyc injects a second start.
  task automatic run_xfer(input int base, input int n, input logic [63:0] low_mask,
                          input int ss_cyc, input int ss_base, input int ss_n);
    bit done_seen;
    done_seen = 1'b0;
    beat_cnt  = 0;
    done_cyc  = -1;
    busy_bits = '0;
    for (int c = 0; c < MaxCyc; c++) begin
      cyc_valid[c] = 1'b0;
      cyc_data[c]  = '0;
      cyc_addr[c]  = '0;
    end
    start_i      = 1'b1;
    base_addr_i  = AW'(base);
    num_words_i  = AW1'(n);
    ready_i      = ~low_mask[0];
    busy_bits[0] = busy_o;
    for (int c = 1; c < MaxCyc && !done_seen; c++) begin
      tick();
      start_i = (c == ss_cyc);
      if (c == ss_cyc) begin
        base_addr_i = AW'(ss_base);
        num_words_i = AW1'(ss_n);
      end
      ready_i      = ~low_mask[c];
      busy_bits[c] = busy_o;
      cyc_valid[c] = valid_o;
      cyc_data[c]  = data_o;
      cyc_addr[c]  = mem_addr_o;
      if (valid_o && ready_i && beat_cnt < 16) begin
        beat_data[beat_cnt] = data_o;
        beat_last[beat_cnt] = last_o;
        beat_cyc[beat_cnt]  = c;
        beat_cnt++;
      end
      if (done_o) begin
        done_seen = 1'b1;
        done_cyc  = c;
        check_eq("done_vs_busy", DW'(busy_o), DW'(0));
      end
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    check_eq("done_seen", DW'(done_seen), DW'(1));
    if (done_seen) begin
      tick();
      check_eq("done_one_cycle", DW'(done_o), DW'(0));
    end
  endtask

  task automatic verify_stream(input string tag, input int base, input int n,
                               input int exp_done, input bit contiguous);
    check_eq({tag, "_beats"}, DW'(beat_cnt), DW'(n));
    for (int i = 0; i < n && i < beat_cnt; i++) begin
      check_eq({tag, "_data"}, beat_data[i], DW'((base + i) % DD));
      check_eq({tag, "_last"}, DW'(beat_last[i]), DW'(i == n - 1));
      if (contiguous) begin
        check_eq({tag, "_cycle"}, DW'(beat_cyc[i]), DW'(i + 2));
      end
    end
    check_eq({tag, "_done_cycle"}, DW'(done_cyc), DW'(exp_done));
    $display("[TB] xfer %s: base=%0d n=%0d beats=%0d done_cycle=%0d",
             tag, base, n, beat_cnt, done_cyc);
  endtask

  initial begin
    for (int i = 0; i < DD; i++) begin
      mem[i] = DW'(i);
    end

    // Power-on reset
    #2 rst_ni = 1'b0;
    tick();
    check_reset_outputs("reset");
    check_eq("reset_we", DW'(mem_we_o), DW'(0));
    tick();
    rst_ni = 1'b1;
    tick();

    // 1: base 5, 4 words, full rate
    run_xfer(5, 4, 64'h0, -1, 0, 0);
    verify_stream("t1", 5, 4, 6, 1'b1);
    check_eq("t1_busy_bits", DW'(busy_bits[7:0]), DW'(8'b0011_1110));
    check_eq("t1_addr_c1",   DW'(cyc_addr[1]),    DW'(5));
    check_eq("t1_valid_c1",  DW'(cyc_valid[1]),   DW'(0));

    // 2: ready low in cycles 3..6, word 6 must hold with no address skip
    run_xfer(5, 4, 64'h78, -1, 0, 0);
    verify_stream("t2", 5, 4, 10, 1'b0);
    for (int i = 0; i < 4 && i < beat_cnt; i++) begin
      check_eq("t2_cycle", DW'(beat_cyc[i]), DW'(exp_cyc_t2[i]));
    end
    for (int c = 3; c <= 6; c++) begin
      check_eq("t2_stall_valid", DW'(cyc_valid[c]), DW'(1));
      check_eq("t2_stall_data",  cyc_data[c],       DW'(6));
      check_eq("t2_stall_addr",  DW'(cyc_addr[c]),  DW'(7));
    end

    // 3: address wrap at the top of memory
    run_xfer(DD - 2, 4, 64'h0, -1, 0, 0);
    verify_stream("t3", DD - 2, 4, 6, 1'b1);
    check_eq("t3_addr_c1", DW'(cyc_addr[1]), DW'(1022));

    // 4: empty transfer
    run_xfer(7, 0, 64'h0, -1, 0, 0);
    verify_stream("t4", 7, 0, 1, 1'b1);
    check_eq("t4_busy_bits", DW'(busy_bits[1:0]), DW'(0));
    check_eq("t4_valid_c1",  DW'(cyc_valid[1]),   DW'(0));

    // 5: second start during FETCH is ignored
    run_xfer(5, 4, 64'h0, 2, 100, 2);
    verify_stream("t5", 5, 4, 6, 1'b1);

    // 6: async reset on beat 2 of 8, then restart from a new base
    start_i     = 1'b1;
    base_addr_i = AW'(10);
    num_words_i = AW1'(8);
    ready_i     = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    check_eq("t6_pre_valid", DW'(valid_o), DW'(1));
    check_eq("t6_pre_data",  data_o,       DW'(11));
    #2 rst_ni = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    $display("[TB] xfer t6_abort: base=10 n=8 aborted by reset on beat 2");
    run_xfer(300, 3, 64'h0, -1, 0, 0);
    verify_stream("t6_after", 300, 3, 5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
